// File: rtl/message_arbiter.sv
// Round-robin arbiter sharing one message_build between ch0/ch1, one whole message per grant.
// Grant takes 1 cycle from IDLE; transfers then pass through combinationally with readies routed to the granted channel only.
module message_arbiter #(
  parameter int DATA_W = 512,
  parameter int SIZE_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [SIZE_W-1:0] ch0_cfg_size,
  input  logic [1:0]        ch0_cfg_scheme,
  input  logic              ch0_cfg_last,
  input  logic              ch0_cfg_valid,
  output logic              ch0_cfg_ready,
  input  logic [DATA_W-1:0] ch0_data,
  input  logic              ch0_data_last,
  input  logic              ch0_data_valid,
  output logic              ch0_data_ready,
  input  logic [SIZE_W-1:0] ch1_cfg_size,
  input  logic [1:0]        ch1_cfg_scheme,
  input  logic              ch1_cfg_last,
  input  logic              ch1_cfg_valid,
  output logic              ch1_cfg_ready,
  input  logic [DATA_W-1:0] ch1_data,
  input  logic              ch1_data_last,
  input  logic              ch1_data_valid,
  output logic              ch1_data_ready,
  output logic [SIZE_W-1:0] cfg_size,
  output logic [1:0]        cfg_scheme,
  output logic              cfg_last,
  output logic              cfg_valid,
  input  logic              cfg_ready,
  output logic [DATA_W-1:0] data_in,
  output logic              data_in_last,
  output logic              data_in_valid,
  input  logic              data_in_ready,
  output logic              grant_id,
  output logic              busy,
  output logic [CNT_W-1:0]  msg_count0,
  output logic [CNT_W-1:0]  msg_count1
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;
  logic             cfg_done_q, cfg_done_d;
  logic             data_done_q, data_done_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic req0, req1, active, cfg_open, data_open;
  logic cfg_hs, data_last_hs;

  assign req0      = ch0_cfg_valid | ch0_data_valid;
  assign req1      = ch1_cfg_valid | ch1_data_valid;
  assign active    = (state_q == ACTIVE);
  // Each path closes independently once its part of the message has been forwarded.
  assign cfg_open  = active & ~cfg_done_q;
  assign data_open = active & ~data_done_q;

  assign cfg_size      = grant_q ? ch1_cfg_size   : ch0_cfg_size;
  assign cfg_scheme    = grant_q ? ch1_cfg_scheme : ch0_cfg_scheme;
  assign cfg_last      = grant_q ? ch1_cfg_last   : ch0_cfg_last;
  assign cfg_valid     = cfg_open & (grant_q ? ch1_cfg_valid : ch0_cfg_valid);
  assign data_in       = grant_q ? ch1_data      : ch0_data;
  assign data_in_last  = grant_q ? ch1_data_last : ch0_data_last;
  assign data_in_valid = data_open & (grant_q ? ch1_data_valid : ch0_data_valid);

  assign ch0_cfg_ready  = cfg_open  & ~grant_q & cfg_ready;
  assign ch1_cfg_ready  = cfg_open  &  grant_q & cfg_ready;
  assign ch0_data_ready = data_open & ~grant_q & data_in_ready;
  assign ch1_data_ready = data_open &  grant_q & data_in_ready;

  assign cfg_hs       = cfg_valid & cfg_ready;
  assign data_last_hs = data_in_valid & data_in_ready & data_in_last;

  assign grant_id   = grant_q;
  assign busy       = active;
  assign msg_count0 = cnt0_q;
  assign msg_count1 = cnt1_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    cfg_done_d  = cfg_done_q;
    data_done_d = data_done_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          grant_d     = (req0 & req1) ? rr_q : req1;
          cfg_done_d  = 1'b0;
          data_done_d = 1'b0;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cfg_hs)       cfg_done_d  = 1'b1;
        if (data_last_hs) data_done_d = 1'b1;
        // Completion includes a final handshake landing in this same cycle.
        if (cfg_done_d & data_done_d) begin
          state_d = IDLE;
          rr_d    = ~grant_q;
          if (grant_q) cnt1_d = cnt1_q + CNT_W'(1);
          else         cnt0_d = cnt0_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      rr_q        <= 1'b0;
      cfg_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      cfg_done_q  <= cfg_done_d;
      data_done_q <= data_done_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_message_arbiter.sv
// Directed bench for message_arbiter: single/dual requests, data-before-cfg, random backpressure, counter wrap, mid-message reset.
module tb_message_arbiter;

  localparam int DATA_W = 32;
  localparam int SIZE_W = 64;
  localparam int CNT_W  = 4;

  logic              clk  = 1'b0;
  logic              nrst = 1'b1;
  logic [SIZE_W-1:0] ch0_cfg_size, ch1_cfg_size, cfg_size;
  logic [1:0]        ch0_cfg_scheme, ch1_cfg_scheme, cfg_scheme;
  logic              ch0_cfg_last, ch1_cfg_last, cfg_last;
  logic              ch0_cfg_valid, ch1_cfg_valid, cfg_valid;
  logic              ch0_cfg_ready, ch1_cfg_ready, cfg_ready;
  logic [DATA_W-1:0] ch0_data, ch1_data, data_in;
  logic              ch0_data_last, ch1_data_last, data_in_last;
  logic              ch0_data_valid, ch1_data_valid, data_in_valid;
  logic              ch0_data_ready, ch1_data_ready, data_in_ready;
  logic              grant_id, busy;
  logic [CNT_W-1:0]  msg_count0, msg_count1;

  int vectors     = 0;
  int miscompares = 0;

  int m[2];
  int b[2];
  bit cacc[2];
  bit dacc[2];

  message_arbiter #(.DATA_W(DATA_W), .SIZE_W(SIZE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst),
    .ch0_cfg_size(ch0_cfg_size), .ch0_cfg_scheme(ch0_cfg_scheme), .ch0_cfg_last(ch0_cfg_last),
    .ch0_cfg_valid(ch0_cfg_valid), .ch0_cfg_ready(ch0_cfg_ready),
    .ch0_data(ch0_data), .ch0_data_last(ch0_data_last), .ch0_data_valid(ch0_data_valid),
    .ch0_data_ready(ch0_data_ready),
    .ch1_cfg_size(ch1_cfg_size), .ch1_cfg_scheme(ch1_cfg_scheme), .ch1_cfg_last(ch1_cfg_last),
    .ch1_cfg_valid(ch1_cfg_valid), .ch1_cfg_ready(ch1_cfg_ready),
    .ch1_data(ch1_data), .ch1_data_last(ch1_data_last), .ch1_data_valid(ch1_data_valid),
    .ch1_data_ready(ch1_data_ready),
    .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_last(cfg_last),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .data_in(data_in), .data_in_last(data_in_last), .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .grant_id(grant_id), .busy(busy), .msg_count0(msg_count0), .msg_count1(msg_count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ch0_cfg_size = '0; ch0_cfg_scheme = '0; ch0_cfg_last = 1'b0; ch0_cfg_valid = 1'b0;
    ch0_data = '0; ch0_data_last = 1'b0; ch0_data_valid = 1'b0;
    ch1_cfg_size = '0; ch1_cfg_scheme = '0; ch1_cfg_last = 1'b0; ch1_cfg_valid = 1'b0;
    ch1_data = '0; ch1_data_last = 1'b0; ch1_data_valid = 1'b0;
    cfg_ready = 1'b0; data_in_ready = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    #1 nrst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic set_ch(input int c, input logic [63:0] sz, input logic [1:0] sch,
                        input logic cv, input logic [31:0] d, input logic dl, input logic dv);
    if (c == 0) begin
      ch0_cfg_size = sz; ch0_cfg_scheme = sch; ch0_cfg_last = 1'b1; ch0_cfg_valid = cv;
      ch0_data = d; ch0_data_last = dl; ch0_data_valid = dv;
    end else begin
      ch1_cfg_size = sz; ch1_cfg_scheme = sch; ch1_cfg_last = 1'b1; ch1_cfg_valid = cv;
      ch1_data = d; ch1_data_last = dl; ch1_data_valid = dv;
    end
  endtask

  function automatic int nbeats(input int mi);
    return (mi % 3) + 1;
  endfunction

  function automatic logic [31:0] dexp(input int c, input int mi, input int bi);
    return 32'(c * 65536 + mi * 256 + bi);
  endfunction

  task automatic drive(input int c);
    set_ch(c, 64'(c * 256 + m[c]), 2'(m[c]), 1'b1, dexp(c, m[c], b[c]),
           b[c] == nbeats(m[c]) - 1, 1'b1);
  endtask

  // Single-beat message with an always-ready sink; returns once busy has risen and fallen.
  task automatic one_msg(input int c, input logic [63:0] sz, input logic [31:0] d);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    set_ch(c, sz, 2'd1, 1'b1, d, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    chk("one_msg_done", {63'd0, seen & ~busy}, 64'd1);
    set_ch(c, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bit pend;
    int pend_ch;
    int g;
    int cfgcnt;
    int done_msgs;
    bit exp_g;

    // ---- reset state ----
    do_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_cnt0", msg_count0, 0);
    chk("rst_cnt1", msg_count1, 0);
    chk("rst_valids", {cfg_valid, data_in_valid}, 0);
    chk("rst_readies", {ch0_cfg_ready, ch0_data_ready, ch1_cfg_ready, ch1_data_ready}, 0);

    // ---- ch0 only, single beat ----
    @(negedge clk);
    cfg_ready = 1'b1; data_in_ready = 1'b1;
    set_ch(0, 64'd24, 2'd0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b1);
    #1;
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_rdy", {ch0_cfg_ready, ch0_data_ready}, 0);
    @(negedge clk); #1;
    chk("t1_busy", busy, 1);
    chk("t1_grant", grant_id, 0);
    chk("t1_cfg_size", cfg_size, 64'd24);
    chk("t1_cfg_fields", {cfg_scheme, cfg_last, cfg_valid}, {2'd0, 1'b1, 1'b1});
    chk("t1_data", data_in, 32'hA5A5_0001);
    chk("t1_data_ctl", {data_in_last, data_in_valid}, 2'b11);
    chk("t1_ch0_rdy", {ch0_cfg_ready, ch0_data_ready}, 2'b11);
    chk("t1_ch1_rdy", {ch1_cfg_ready, ch1_data_ready}, 0);
    @(negedge clk); #1;
    chk("t1_done_busy", busy, 0);
    chk("t1_cnt0", msg_count0, 1);
    chk("t1_ch1_rdy_end", {ch1_cfg_ready, ch1_data_ready}, 0);
    set_ch(0, '0, '0, 1'b0, '0, 1'b0, 1'b0);

    // ---- both request together after reset ----
    do_reset();
    cfg_ready = 1'b1; data_in_ready = 1'b1;
    set_ch(0, 64'd100, 2'd1, 1'b1, 32'h1000_0001, 1'b1, 1'b1);
    set_ch(1, 64'd200, 2'd2, 1'b1, 32'h2000_0001, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("t2_g0_busy", busy, 1);
    chk("t2_g0_grant", grant_id, 0);
    chk("t2_g0_size", cfg_size, 64'd100);
    chk("t2_g0_ch1rdy", {ch1_cfg_ready, ch1_data_ready}, 0);
    @(negedge clk); #1;
    chk("t2_gap_busy", busy, 0);
    chk("t2_cnt0_a", msg_count0, 1);
    set_ch(0, 64'd101, 2'd1, 1'b1, 32'h1000_0002, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("t2_g1_busy", busy, 1);
    chk("t2_g1_grant", grant_id, 1);
    chk("t2_g1_size", cfg_size, 64'd200);
    chk("t2_g1_data", data_in, 32'h2000_0001);
    chk("t2_g1_ch0rdy", {ch0_cfg_ready, ch0_data_ready}, 0);
    @(negedge clk); #1;
    chk("t2_cnt1", msg_count1, 1);
    set_ch(1, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("t2_g2_grant", {busy, grant_id}, 2'b10);
    chk("t2_g2_size", cfg_size, 64'd101);
    @(negedge clk); #1;
    chk("t2_cnt0_b", msg_count0, 2);
    chk("t2_cnt1_b", msg_count1, 1);
    set_ch(0, '0, '0, 1'b0, '0, 1'b0, 1'b0);

    // ---- ch1, 3 beats, data before cfg, cfg_ready low 5 cycles ----
    do_reset();
    data_in_ready = 1'b1;
    set_ch(1, 64'd48, 2'd2, 1'b0, 32'hD000_0000, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("t3_grant", {busy, grant_id}, 2'b11);
    chk("t3_cfg_valid0", cfg_valid, 0);
    chk("t3_beat0", data_in, 32'hD000_0000);
    chk("t3_rdy0", {ch1_data_ready, ch0_data_ready}, 2'b10);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      cfg_ready = (k == 5);
      if (k <= 2) set_ch(1, 64'd48, 2'd2, 1'b1, 32'hD000_0000 + 32'(k), k == 2, 1'b1);
      #1;
      chk("t3_busy", busy, 1);
      chk("t3_cfg_valid", cfg_valid, 1);
      chk("t3_cfg_rdy", ch1_cfg_ready, (k == 5));
      if (k <= 2) begin
        chk("t3_beat", data_in, 32'hD000_0000 + 32'(k));
        chk("t3_drdy", ch1_data_ready, 1);
      end else begin
        chk("t3_dmask", {data_in_valid, ch1_data_ready}, 0);
      end
    end
    chk("t3_cfg_size", cfg_size, 64'd48);
    @(negedge clk); #1;
    chk("t3_done", {busy, cfg_valid}, 0);
    chk("t3_cnt1", msg_count1, 1);
    set_ch(1, '0, '0, 1'b0, '0, 1'b0, 1'b0);

    // ---- 20 alternating messages under random backpressure ----
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      m[c] = 0; b[c] = 0; cacc[c] = 1'b0; dacc[c] = 1'b0;
      drive(c);
    end
    pend = 1'b0; pend_ch = 0; cfgcnt = 0; done_msgs = 0; exp_g = 1'b0;
    for (int cyc = 0; cyc < 2000 && done_msgs < 20; cyc++) begin
      @(negedge clk);
      if (pend) drive(pend_ch);
      pend = 1'b0;
      cfg_ready     = 1'($urandom_range(0, 1));
      data_in_ready = 1'($urandom_range(0, 1));
      #1;
      if (busy) begin
        g = int'(grant_id);
        chk("rr_grant", grant_id, exp_g);
        if (cfg_valid && cfg_ready) begin
          chk("rr_cfg_size", cfg_size, 64'(g * 256 + m[g]));
          cfgcnt++;
          cacc[g] = 1'b1;
        end
        if (data_in_valid && data_in_ready) begin
          chk("rr_data", data_in, dexp(g, m[g], b[g]));
          chk("rr_last", data_in_last, b[g] == nbeats(m[g]) - 1);
          if (b[g] == nbeats(m[g]) - 1) dacc[g] = 1'b1;
          else b[g]++;
          pend = 1'b1; pend_ch = g;
        end
        if (cacc[g] && dacc[g]) begin
          chk("rr_cfg_count", 64'(cfgcnt), 1);
          m[g]++; b[g] = 0; cacc[g] = 1'b0; dacc[g] = 1'b0;
          cfgcnt = 0; done_msgs++; exp_g = ~exp_g;
          pend = 1'b1; pend_ch = g;
        end
      end else begin
        chk("rr_idle_rdy", {ch0_cfg_ready, ch0_data_ready, ch1_cfg_ready, ch1_data_ready}, 0);
      end
    end
    chk("rr_all_done", 64'(done_msgs), 20);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("rr_cnt0", msg_count0, 10);
    chk("rr_cnt1", msg_count1, 11);

    // ---- counter wrap (CNT_W=4) ----
    do_reset();
    cfg_ready = 1'b1; data_in_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      one_msg(0, 64'(i), 32'(i));
      cfg_ready = 1'b1; data_in_ready = 1'b1;
      if (i == 15) chk("wrap_cnt15", msg_count0, 15);
    end
    chk("wrap_cnt0", msg_count0, 0);
    one_msg(0, 64'd99, 32'd99);
    chk("wrap_cnt1", msg_count0, 1);

    // ---- reset during beat 2 of a 4-beat ch0 message ----
    @(negedge clk);
    set_ch(0, 64'd64, 2'd3, 1'b1, 32'hE000_0000, 1'b0, 1'b1);
    @(negedge clk); #1;
    chk("t6_grant", {busy, grant_id}, 2'b10);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      set_ch(0, 64'd64, 2'd3, 1'b1, 32'hE000_0000 + 32'(k), 1'b0, 1'b1);
    end
    #1;
    chk("t6_beat2", {busy, ch0_data_ready, cfg_valid}, 3'b110);
    #1 nrst = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rdy", {ch0_cfg_ready, ch0_data_ready, ch1_cfg_ready, ch1_data_ready}, 0);
    chk("t6_rst_valid", {cfg_valid, data_in_valid}, 0);
    chk("t6_rst_cnt0", msg_count0, 0);
    @(negedge clk);
    nrst = 1'b1;
    set_ch(0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
    set_ch(1, 64'd7, 2'd1, 1'b1, 32'hF000_0001, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("t6_ch1_grant", {busy, grant_id}, 2'b11);
    chk("t6_ch1_data", data_in, 32'hF000_0001);
    chk("t6_cnts", {msg_count0, msg_count1}, 0);
    @(negedge clk); #1;
    chk("t6_ch1_cnt", {busy, msg_count0, msg_count1}, {1'b0, 4'd0, 4'd1});
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
